// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised horizontal/vertical video timing generator.
// Counters advance on pix_en. Every output is registered and decoded from the
// next counter value, so blank/sync/strobes line up with h_count/v_count.
module vga_timing_gen #(
    parameter int CW        = 10,
    parameter int H_VISIBLE = 400,
    parameter int H_FRONT   = 10,
    parameter int H_SYNC    = 74,
    parameter int H_BACK    = 44,
    parameter int V_VISIBLE = 300,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          blank,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Refuse to build with timings the counters cannot represent.
    generate
        if ((H_TOTAL > 2**CW) || (V_TOTAL > 2**CW) ||
            (H_VISIBLE < 1) || (H_FRONT < 1) || (H_SYNC < 1) || (H_BACK < 1) ||
            (V_VISIBLE < 1) || (V_FRONT < 1) || (V_SYNC < 1) || (V_BACK < 1)) begin : g_param_check
            $error("vga_timing_gen: invalid timing parameters");
        end
    endgenerate

    // Decode thresholds sized to the counters. The sync end never exceeds
    // TOTAL-1 because the back porch is at least one unit.
    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS_END    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS_END    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] H_SYNC_START = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] H_SYNC_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_START = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] V_SYNC_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CW-1:0] r_h_count;
    logic [CW-1:0] r_v_count;
    logic          r_blank;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic          w_blank_next;
    logic          w_hsync_act;
    logic          w_vsync_act;

    // Next-count and decode of the position the counters are about to show.
    always_comb begin
        w_h_wrap     = (r_h_count == H_LAST);
        w_v_wrap     = w_h_wrap && (r_v_count == V_LAST);
        w_h_next     = w_h_wrap ? '0 : r_h_count + CW'(1);
        w_v_next     = r_v_count;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? '0 : r_v_count + CW'(1);
        end
        w_blank_next = (w_h_next >= H_VIS_END) || (w_v_next >= V_VIS_END);
        w_hsync_act  = (w_h_next >= H_SYNC_START) && (w_h_next < H_SYNC_END);
        w_vsync_act  = (w_v_next >= V_SYNC_START) && (w_v_next < V_SYNC_END);
    end

    // Timing state: advance on pix_en, hold otherwise; strobes last one clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_count     <= '0;
            r_v_count     <= '0;
            r_blank       <= 1'b0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (pix_en) begin
            r_h_count     <= w_h_next;
            r_v_count     <= w_v_next;
            r_blank       <= w_blank_next;
            r_hsync       <= w_hsync_act ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_vsync_act ? VSYNC_POL : ~VSYNC_POL;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign h_count     = r_h_count;
    assign v_count     = r_v_count;
    assign blank       = r_blank;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a small
// positive-polarity instance, each tracked by a behavioural model whose
// per-cycle expectations go through a scoreboard queue.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, pix_en;
    logic [9:0] h_count, v_count;
    logic       blank, hsync, vsync, line_start, frame_start;

    logic       rst_s, pix_en_s;
    logic [3:0] h_s, v_s;
    logic       blank_s, hsync_s, vsync_s, ls_s, fs_s;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_count(h_count), .v_count(v_count), .blank(blank),
        .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start)
    );

    vga_timing_gen #(
        .CW(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst_s), .pix_en(pix_en_s),
        .h_count(h_s), .v_count(v_s), .blank(blank_s),
        .hsync(hsync_s), .vsync(vsync_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       blank;
        logic       hsync;
        logic       vsync;
        logic       ls;
        logic       fs;
    } obs_t;

    obs_t q_big[$];
    obs_t q_small[$];
    int   mh, mv, sh, sv;
    obs_t mprev, sprev;
    int   checks = 0;
    int   failures = 0;

    localparam obs_t RST_BIG   = '{h: 10'd0, v: 10'd0, blank: 1'b0, hsync: 1'b1, vsync: 1'b1, ls: 1'b0, fs: 1'b0};
    localparam obs_t RST_SMALL = '{h: 10'd0, v: 10'd0, blank: 1'b0, hsync: 1'b0, vsync: 1'b0, ls: 1'b0, fs: 1'b0};

    // Behavioural model of one pixel-clock step.
    function automatic obs_t model(input obs_t prev, inout int h, inout int v, input bit en,
                                   input int hvis, input int hfp, input int hsw, input int hbp,
                                   input int vvis, input int vfp, input int vsw, input int vbp,
                                   input bit hpol, input bit vpol);
        obs_t o;
        int ht, vt;
        ht = hvis + hfp + hsw + hbp;
        vt = vvis + vfp + vsw + vbp;
        o = prev;
        o.ls = 1'b0;
        o.fs = 1'b0;
        if (en) begin
            h = h + 1;
            if (h == ht) begin
                h = 0;
                o.ls = 1'b1;
                v = v + 1;
                if (v == vt) begin
                    v = 0;
                    o.fs = 1'b1;
                end
            end
            o.h     = 10'(h);
            o.v     = 10'(v);
            o.blank = (h >= hvis) || (v >= vvis);
            o.hsync = ((h >= hvis + hfp) && (h < hvis + hfp + hsw)) ? hpol : ~hpol;
            o.vsync = ((v >= vvis + vfp) && (v < vvis + vfp + vsw)) ? vpol : ~vpol;
        end
        return o;
    endfunction

    function automatic obs_t big_obs();
        return {h_count, v_count, blank, hsync, vsync, line_start, frame_start};
    endfunction

    function automatic obs_t small_obs();
        return {6'd0, h_s, 6'd0, v_s, blank_s, hsync_s, vsync_s, ls_s, fs_s};
    endfunction

    // Drive one clk of enables and push both instances' expected outputs.
    task automatic tick(input bit en, input bit en_s);
        pix_en   = en;
        pix_en_s = en_s;
        mprev = model(mprev, mh, mv, en, 400, 10, 74, 44, 300, 1, 4, 23, 1'b0, 1'b0);
        sprev = model(sprev, sh, sv, en_s, 8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1);
        q_big.push_back(mprev);
        q_small.push_back(sprev);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b0; rst_s = 1'b0; pix_en = 1'b1; pix_en_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            got = big_obs();
            checks++;
            if (got !== RST_BIG) begin
                failures++;
                $display("FAIL reset_big cycle=%0d got=%h exp=%h", i, got, RST_BIG);
            end
            got = small_obs();
            checks++;
            if (got !== RST_SMALL) begin
                failures++;
                $display("FAIL reset_small cycle=%0d got=%h exp=%h", i, got, RST_SMALL);
            end
        end
        rst = 1'b1; rst_s = 1'b1;
        mh = 0; mv = 0; mprev = RST_BIG;
        sh = 0; sv = 0; sprev = RST_SMALL;
        q_big.delete();
        q_small.delete();
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_line();
        obs_t got, exp;
        int ls_n = 0, hs_n = 0, hs_first = 1023, hs_last = -1, blank_h = -1;
        for (int i = 0; i < 530; i++) begin
            tick(1'b1, 1'b0);
            exp = q_big.pop_front();
            got = big_obs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL line_cycle i=%0d got=%h exp=%h", i, got, exp);
            end
            if (line_start) ls_n++;
            if (!hsync) begin
                hs_n++;
                if (int'(h_count) < hs_first) hs_first = int'(h_count);
                hs_last = int'(h_count);
            end
            if (blank && blank_h < 0) blank_h = int'(h_count);
        end
        checks++;
        if (ls_n != 1) begin failures++; $display("FAIL line_start_pulses got=%0d exp=1", ls_n); end
        checks++;
        if (hs_n != 74) begin failures++; $display("FAIL hsync_width got=%0d exp=74", hs_n); end
        checks++;
        if (hs_first != 410 || hs_last != 483) begin
            failures++;
            $display("FAIL hsync_window got=%0d..%0d exp=410..483", hs_first, hs_last);
        end
        checks++;
        if (blank_h != 400) begin failures++; $display("FAIL blank_rise got=%0d exp=400", blank_h); end
        checks++;
        if (v_count !== 10'd1) begin failures++; $display("FAIL line_v_advance got=%0d exp=1", v_count); end
        $display("test_line done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_small_frame();
        obs_t got, exp;
        int fs_n = 0, vs_n = 0, hs_n = 0;
        q_small.delete();
        for (int i = 0; i < 112; i++) begin
            tick(1'b0, 1'b1);
            exp = q_small.pop_front();
            got = small_obs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL frame_cycle i=%0d got=%h exp=%h", i, got, exp);
            end
            if (fs_s) fs_n++;
            if (vsync_s) vs_n++;
            if (hsync_s) hs_n++;
        end
        checks++;
        if (fs_n != 1 || !fs_s) begin
            failures++;
            $display("FAIL frame_start_pulse got=%0d last=%b exp=1 last=1", fs_n, fs_s);
        end
        checks++;
        if (vs_n != 28) begin failures++; $display("FAIL vsync_cycles got=%0d exp=28", vs_n); end
        checks++;
        if (hs_n != 24) begin failures++; $display("FAIL hsync_cycles got=%0d exp=24", hs_n); end
        $display("test_small_frame done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_enable_gating();
        obs_t got, exp;
        int ls_n = 0;
        q_small.delete();
        for (int i = 0; i < 120; i++) begin
            tick(1'b0, (i % 4) == 0);
            exp = q_small.pop_front();
            got = small_obs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL gate_cycle i=%0d got=%h exp=%h", i, got, exp);
            end
            if (ls_s) ls_n++;
        end
        checks++;
        if (ls_n != 2) begin failures++; $display("FAIL gate_strobe_clks got=%0d exp=2", ls_n); end
        checks++;
        if (h_s !== 4'd2 || v_s !== 4'd2) begin
            failures++;
            $display("FAIL gate_position got=(%0d,%0d) exp=(2,2)", h_s, v_s);
        end
        $display("test_enable_gating done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_mid_frame_reset();
        obs_t got, exp;
        int guard = 0;
        q_big.delete();
        while (!(mh == 200 && mv == 5) && guard < 5000) begin
            tick(1'b1, 1'b0);
            guard++;
            exp = q_big.pop_front();
            got = big_obs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL run_cycle i=%0d got=%h exp=%h", guard, got, exp);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        got = big_obs();
        checks++;
        if (got !== RST_BIG) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", got, RST_BIG);
        end
        @(posedge clk);
        #1;
        got = big_obs();
        checks++;
        if (got !== RST_BIG) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", got, RST_BIG);
        end
        rst = 1'b1;
        mh = 0; mv = 0; mprev = RST_BIG;
        q_big.delete();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            exp = q_big.pop_front();
            got = big_obs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL restart i=%0d got=%h exp=%h", i, got, exp);
            end
        end
        checks++;
        if (h_count !== 10'd3 || v_count !== 10'd0) begin
            failures++;
            $display("FAIL restart_position got=(%0d,%0d) exp=(3,0)", h_count, v_count);
        end
        $display("test_mid_frame_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        rst = 1'b0; rst_s = 1'b0; pix_en = 1'b0; pix_en_s = 1'b0;
        mh = 0; mv = 0; sh = 0; sv = 0;
        mprev = RST_BIG; sprev = RST_SMALL;
        #1;
        test_reset();
        test_line();
        test_small_frame();
        test_enable_gating();
        test_mid_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
